// File: rtl/keypad_matrix_emulator_pkg.sv
// rtl/keypad_matrix_emulator_pkg.sv - key codes, FSM states and key-to-matrix mapping
package keypad_matrix_emulator_pkg;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rowcol_t;

    // Position of a key in the 4x4 matrix; shared with the scanning decoder
    function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
        rowcol_t rc;
        rc = '0;
        case (code)
            4'h1:     rc = '{row: 2'd0, col: 2'd0};
            4'h2:     rc = '{row: 2'd0, col: 2'd1};
            4'h3:     rc = '{row: 2'd0, col: 2'd2};
            KEY_A:    rc = '{row: 2'd0, col: 2'd3};
            4'h4:     rc = '{row: 2'd1, col: 2'd0};
            4'h5:     rc = '{row: 2'd1, col: 2'd1};
            4'h6:     rc = '{row: 2'd1, col: 2'd2};
            KEY_B:    rc = '{row: 2'd1, col: 2'd3};
            4'h7:     rc = '{row: 2'd2, col: 2'd0};
            4'h8:     rc = '{row: 2'd2, col: 2'd1};
            4'h9:     rc = '{row: 2'd2, col: 2'd2};
            KEY_C:    rc = '{row: 2'd2, col: 2'd3};
            KEY_STAR: rc = '{row: 2'd3, col: 2'd0};
            4'h0:     rc = '{row: 2'd3, col: 2'd1};
            KEY_HASH: rc = '{row: 2'd3, col: 2'd2};
            KEY_D:    rc = '{row: 2'd3, col: 2'd3};
            default:  rc = '0;
        endcase
        return rc;
    endfunction

    // Largest of three timing parameters, used to size the shared counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_counter.sv
// rtl/keypad_matrix_emulator_counter.sv - loadable down counter with zero flag
module emu_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; counting stops at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// rtl/keypad_matrix_emulator.sv - 4x4 keypad switch-matrix model; optional contact bounce under KEYPAD_EMU_BOUNCE_EN
module keypad_matrix_emulator
    import keypad_matrix_emulator_pkg::*;
#(
    parameter int HOLD_CYCLES    = 200,
    parameter int RELEASE_CYCLES = 100,
    parameter int BOUNCE_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] matricial_lin,
    output logic [3:0] matricial_col,
    output logic       busy,
    output logic [7:0] keys_sent
);

    localparam int CW = $clog2(max3(HOLD_CYCLES, RELEASE_CYCLES, BOUNCE_CYCLES) + 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);

    emu_state_t    state;
    emu_state_t    state_next;
    logic          contact;
    logic          contact_next;
    logic [1:0]    row_q;
    logic [1:0]    col_q;
    rowcol_t       key_pos;
    logic          accept;
    logic          sent_inc;
    logic          cnt_load;
    logic [CW-1:0] cnt_value;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          press_contact;
    logic          release_contact;

    assign key_pos = key_to_rowcol(key_code);

    emu_down_counter #(
        .WIDTH(CW)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(cnt_value),
        .enable    (state != IDLE),
        .count     (cnt),
        .zero      (cnt_zero)
    );

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CW-1:0] HOLD_LEN    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] RELEASE_LEN = CW'(RELEASE_CYCLES);
    localparam logic [CW-1:0] BOUNCE_LEN  = CW'(BOUNCE_CYCLES);

    // Index within the phase of the cycle the next edge enters; the
    // counter reads N-1-index during a phase of length N.
    logic [CW-1:0] press_idx;
    logic [CW-1:0] release_idx;
    assign press_idx       = HOLD_LEN - cnt;
    assign release_idx     = RELEASE_LEN - cnt;
    assign press_contact   = (press_idx < BOUNCE_LEN) ? ~press_idx[0] : 1'b1;
    assign release_contact = (release_idx < BOUNCE_LEN) ? release_idx[0] : 1'b0;
`else
    assign press_contact   = 1'b1;
    assign release_contact = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake, counter control and next contact level
    always_comb begin
        state_next   = state;
        key_ready    = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;
        sent_inc     = 1'b0;
        cnt_load     = 1'b0;
        cnt_value    = HOLD_LOAD;
        contact_next = contact;
        case (state)
            IDLE: begin
                key_ready    = 1'b1;
                contact_next = 1'b0;
                if (key_valid) begin
                    accept       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_value    = HOLD_LOAD;
                    contact_next = 1'b1;
                    state_next   = PRESS;
                end
            end
            PRESS: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    contact_next = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_value    = RELEASE_LOAD;
                    state_next   = RELEASE;
                end else begin
                    contact_next = press_contact;
                end
            end
            RELEASE: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    contact_next = 1'b0;
                    sent_inc     = 1'b1;
                    state_next   = IDLE;
                end else begin
                    contact_next = release_contact;
                end
            end
            default: begin
                contact_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    // Contact level, latched key position and completed-press count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            contact   <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            keys_sent <= 8'd0;
        end else begin
            contact <= contact_next;
            if (accept) begin
                row_q <= key_pos.row;
                col_q <= key_pos.col;
            end
            if (sent_inc) begin
                keys_sent <= keys_sent + 8'd1;
            end
        end
    end

    // Column return follows the row drive within the same cycle
    always_comb begin
        matricial_col = 4'hF;
        if (contact && !matricial_lin[row_q]) begin
            matricial_col[col_q] = 1'b0;
        end
    end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable 4x4 keypad model: the switch-matrix end of the keypad scan interface.
- Accepts a key code through a valid/ready handshake and "presses" that key for a programmed time.
- Answers the scanning decoder's row drive on matricial_lin by pulling the matching column of matricial_col low.
- Used in hardware-in-loop and self-test builds in place of the physical keypad, on the divided clock domain.

Parameters:
- HOLD_CYCLES, 200, cycles the key stays pressed (minimum 1).
- RELEASE_CYCLES, 100, cycles of guaranteed release gap before the next key is accepted (minimum 1).
- BOUNCE_CYCLES, 8, bounce window length at press and release edges (used only with the optional feature).

Ports:
- clk  in  1  system clock (divided clock domain).
- rst  in  1  reset; asynchronous, active-low.
- key_code  in  4  key to press: 0x0-0x9 digits, 0xA-0xD letters, 0xE '*', 0xF '#'.
- key_valid  in  1  key_code is valid this cycle.
- key_ready  out  1  emulator can accept a key.
- matricial_lin  in  4  row drive from the decoder; active-low, 0 = row selected.
- matricial_col  out  4  column return; idle 1 (pull-up); pressed key pulls its column to 0.
- busy  out  1  a press or release gap is in progress.
- keys_sent  out  8  count of completed presses; wraps 255 -> 0.

Behaviour:
- Key map (row, col):
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- FSM states IDLE, PRESS, RELEASE. Reset drives all registers immediately to IDLE: key_ready=1, busy=0, keys_sent=0, internal contact=0, matricial_col=4'hF.
- IDLE: key_ready=1. When key_valid&&key_ready:
  - latch key_code into key_q;
  - load the counter with HOLD_CYCLES-1;
  - go to PRESS next cycle with contact=1.
- PRESS: key_ready=0, busy=1. The counter decrements each cycle; at 0:
  - contact=0;
  - counter loaded with RELEASE_CYCLES-1;
  - go to RELEASE.
  - Contact is therefore asserted for exactly HOLD_CYCLES cycles.
- RELEASE: busy=1, contact=0. At counter 0:
  - keys_sent increments;
  - go to IDLE;
  - key_ready returns to 1 the following cycle.
- matricial_col is combinational from matricial_lin and the registered contact, row_q and col_q, so a row change is reflected in the same cycle:
  - col bit col_q = 0 iff contact && matricial_lin[row_q]==0;
  - all other bits are 1.
- Multiple rows low: the column is pulled if the key's row is among them.
- matricial_lin = 4'hF: matricial_col = 4'hF.
- key_valid while not ready: ignored, not queued.
- key_code changes after acceptance: no effect.
- Reset mid-PRESS: the column releases asynchronously with rst, and keys_sent is not incremented.
- Counter width is $clog2(max(HOLD_CYCLES, RELEASE_CYCLES, BOUNCE_CYCLES)+1).

Optional Feature:
- Macro KEYPAD_EMU_BOUNCE_EN.
- When defined:
  - for the first BOUNCE_CYCLES cycles of PRESS and the first BOUNCE_CYCLES cycles of RELEASE, contact toggles every cycle, starting at 1 in PRESS and at 0 in RELEASE;
  - after the window, contact is steady;
  - total PRESS and RELEASE durations are unchanged.
- When undefined: contact is clean, as described above, and the bounce logic is absent.

Decomposition:
- Shared package: key code constants (KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_A..KEY_D) and a function key_to_rowcol(code) returning 2-bit row and 2-bit col. The decoder side reuses the same function.
- One natural sub-module, emu_down_counter: a loadable down counter with a zero flag, shared by the PRESS, RELEASE and bounce timing.

Test Plan:
- Reset: rst=0 mid-PRESS of key 5 -> matricial_col=4'hF immediately, key_ready=1 and keys_sent=0 after release of reset.
- key_code=0x5, key_valid 1 cycle, HOLD=4, RELEASE=2 with matricial_lin=4'b1101:
  - matricial_col=4'b1101 for exactly 4 cycles starting 1 cycle after acceptance;
  - key_ready returns 7 cycles after acceptance;
  - keys_sent=1.
- Key 0xE ('*') held, lin swept 1110, 1101, 1011, 0111 -> col=4'hF, 4'hF, 4'hF, 4'b1110 respectively.
- Key 0xD with lin=4'b0000 -> col=4'b0111; with lin=4'hF -> col=4'hF.
- key_valid held high with codes 1, 2, 3 -> three presses back to back separated by RELEASE_CYCLES; no codes taken while busy; keys_sent=3.
- KEYPAD_EMU_BOUNCE_EN, BOUNCE=4, HOLD=10, key 1, lin=4'b1110:
  - col[0] sequence 0,1,0,1 then 0 for 6 cycles;
  - release window 1,0,1,0 then steady 1.
